// File: rtl/param_fir_filter_if.sv
// param_fir_filter_if: sample-source, coefficient-load and output-sink signals
// of the FIR filter, grouped for port connection.
interface param_fir_filter_if #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned COEFF_W = 16
);
  logic               load_coeff;
  logic               coeff_valid;
  logic [COEFF_W-1:0] fir_coefficient;
  logic               data_ready;
  logic [DATA_W-1:0]  sample_data;
  logic               modwait;
  logic               out_valid;
  logic [DATA_W-1:0]  fir_out;
  logic               err;
  logic               one_k_samples;

  modport master (
    output load_coeff, coeff_valid, fir_coefficient, data_ready, sample_data,
    input  modwait, out_valid, fir_out, err, one_k_samples
  );

  modport slave (
    input  load_coeff, coeff_valid, fir_coefficient, data_ready, sample_data,
    output modwait, out_valid, fir_out, err, one_k_samples
  );
endinterface

// File: rtl/param_fir_filter.sv
// param_fir_filter: serial multiply-accumulate FIR, one tap per clock, even taps
// add and odd taps subtract, result saturated to the unsigned output range.
// Optional build macro FIR_ROUND_EN: round half up before the output shift.
module param_fir_filter #(
  parameter int unsigned NUM_TAPS   = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned COEFF_W    = 16,
  parameter int unsigned SAMPLE_CNT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  param_fir_filter_if.slave bus
);
  localparam int unsigned TAP_W  = $clog2(NUM_TAPS);
  localparam int unsigned PROD_W = DATA_W + COEFF_W;
  localparam int unsigned ACC_W  = DATA_W + COEFF_W + $clog2(NUM_TAPS) + 1;
  localparam int unsigned CNT_W  = (SAMPLE_CNT > 1) ? $clog2(SAMPLE_CNT) : 1;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLE_CNT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, MAC, OUT} state_t;

  state_t                     state_q, state_d;
  logic                       dr_q;
  logic [COEFF_W-1:0]         coeff_q [NUM_TAPS];
  logic [COEFF_W-1:0]         coeff_d [NUM_TAPS];
  logic [DATA_W-1:0]          hist_q  [NUM_TAPS];
  logic [DATA_W-1:0]          hist_d  [NUM_TAPS];
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [TAP_W-1:0]           tap_q, tap_d;
  logic [TAP_W-1:0]           idx_q, idx_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       modwait_q, modwait_d;
  logic                       out_valid_q, out_valid_d;
  logic                       err_q, err_d;
  logic                       one_k_q, one_k_d;
  logic [DATA_W-1:0]          fir_out_q, fir_out_d;

  logic                       dr_edge;
  logic [PROD_W-1:0]          prod;
  logic signed [ACC_W-1:0]    term;
  logic signed [ACC_W-1:0]    acc_adj;
  logic signed [ACC_W-1:0]    result;
  logic [DATA_W-1:0]          sat_val;
  logic                       clip;

  assign dr_edge = bus.data_ready & ~dr_q;

  // Product for the current tap, negated on odd taps
  always_comb begin
    prod = PROD_W'(hist_q[tap_q]) * PROD_W'(coeff_q[tap_q]);
    term = tap_q[0] ? -$signed(ACC_W'(prod)) : $signed(ACC_W'(prod));
  end

  // Scale accumulator back to sample units and saturate to the output range
  always_comb begin
`ifdef FIR_ROUND_EN
    acc_adj = acc_q + $signed(ACC_W'(1) << (COEFF_W - 2));
`else
    acc_adj = acc_q;
`endif
    result  = acc_adj >>> (COEFF_W - 1);
    sat_val = result[DATA_W-1:0];
    clip    = 1'b0;
    if (result[ACC_W-1]) begin
      sat_val = '0;
      clip    = 1'b1;
    end else if (|result[ACC_W-2:DATA_W]) begin
      sat_val = '1;
      clip    = 1'b1;
    end
  end

  // Next-state and datapath updates for every state
  always_comb begin
    state_d     = state_q;
    coeff_d     = coeff_q;
    hist_d      = hist_q;
    acc_d       = acc_q;
    tap_d       = tap_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    modwait_d   = modwait_q;
    out_valid_d = 1'b0;
    one_k_d     = 1'b0;
    err_d       = err_q;
    fir_out_d   = fir_out_q;

    unique case (state_q)
      IDLE: begin
        if (bus.load_coeff) begin
          // Load request takes priority; a coincident sample is lost
          state_d = LOAD;
          if (dr_edge) err_d = 1'b1;
        end else if (dr_edge) begin
          state_d = MAC;
          for (int unsigned i = NUM_TAPS - 1; i > 0; i--) begin
            hist_d[TAP_W'(i)] = hist_q[TAP_W'(i - 1)];
          end
          hist_d[0] = bus.sample_data;
          acc_d     = '0;
          tap_d     = '0;
          err_d     = 1'b0;
          modwait_d = 1'b1;
        end
      end
      LOAD: begin
        if (dr_edge) err_d = 1'b1;
        if (!bus.load_coeff) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (bus.coeff_valid) begin
          coeff_d[idx_q] = bus.fir_coefficient;
          if (idx_q != LAST_TAP) idx_d = idx_q + 1'b1;
        end
      end
      MAC: begin
        if (dr_edge) err_d = 1'b1;
        acc_d = acc_q + term;
        if (tap_q == LAST_TAP) begin
          state_d = OUT;
          tap_d   = '0;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      OUT: begin
        state_d     = IDLE;
        fir_out_d   = sat_val;
        out_valid_d = 1'b1;
        modwait_d   = 1'b0;
        err_d       = err_q | clip | dr_edge;
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          one_k_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath, history, coefficient and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dr_q        <= 1'b0;
      coeff_q     <= '{default: '0};
      hist_q      <= '{default: '0};
      acc_q       <= '0;
      tap_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      modwait_q   <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      one_k_q     <= 1'b0;
      fir_out_q   <= '0;
    end else begin
      dr_q        <= bus.data_ready;
      coeff_q     <= coeff_d;
      hist_q      <= hist_d;
      acc_q       <= acc_d;
      tap_q       <= tap_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      modwait_q   <= modwait_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      one_k_q     <= one_k_d;
      fir_out_q   <= fir_out_d;
    end
  end

  assign bus.modwait       = modwait_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.fir_out       = fir_out_q;
  assign bus.err           = err_q;
  assign bus.one_k_samples = one_k_q;
endmodule

// File: tb/tb_param_fir_filter.sv
// tb_param_fir_filter: directed and randomized checks of param_fir_filter
// against an arithmetic reference model of the tap sum and saturation.
module tb_param_fir_filter;
  localparam int NT = 4;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int SC = 3;
`ifdef FIR_ROUND_EN
  localparam logic [15:0] T2_THIRD = 16'h1754;
`else
  localparam logic [15:0] T2_THIRD = 16'h1753;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  logic [15:0] m_coeff [NT];
  logic [15:0] m_hist  [NT];
  int          m_outs;
  logic [15:0] cq [$];

  param_fir_filter_if #(.DATA_W(DW), .COEFF_W(CW)) bus ();

  param_fir_filter #(
    .NUM_TAPS  (NT),
    .DATA_W    (DW),
    .COEFF_W   (CW),
    .SAMPLE_CNT(SC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      m_coeff[i] = '0;
      m_hist[i]  = '0;
    end
    m_outs = 0;
  endtask

  // Alternating-sign weighted sum, scaled by 2^-(CW-1), clamped to [0, 2^DW-1]
  task automatic model_out(output logic [15:0] fo, output bit clip);
    longint acc = 0;
    for (int i = 0; i < NT; i++) begin
      longint p = longint'(m_hist[i]) * longint'(m_coeff[i]);
      acc = (i % 2 == 0) ? acc + p : acc - p;
    end
`ifdef FIR_ROUND_EN
    acc = acc + (longint'(1) << (CW - 2));
`endif
    acc = acc >>> (CW - 1);
    if (acc < 0) begin
      fo = 16'h0000; clip = 1'b1;
    end else if (acc > longint'((1 << DW) - 1)) begin
      fo = 16'hFFFF; clip = 1'b1;
    end else begin
      fo = acc[15:0]; clip = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    tick();
    model_reset();
  endtask

  task automatic load_coeffs(input bit with_dr);
    bus.load_coeff = 1'b1;
    if (with_dr) begin
      bus.data_ready  = 1'b1;
      bus.sample_data = 16'hDEAD;
    end
    tick();
    if (with_dr) begin
      check("load_vs_sample_err", bus.err, 1);
      bus.data_ready = 1'b0;
    end
    foreach (cq[i]) begin
      bus.coeff_valid     = 1'b1;
      bus.fir_coefficient = cq[i];
      tick();
      m_coeff[(i < NT) ? i : NT - 1] = cq[i];
    end
    bus.coeff_valid = 1'b0;
    bus.load_coeff  = 1'b0;
    tick();
  endtask

  task automatic random_coeffs();
    cq = {};
    for (int i = 0; i < NT; i++) cq.push_back(16'($urandom_range(0, 16'hFFFF)));
  endtask

  // One full sample transaction; ovr>0 injects a second edge that many cycles
  // after accept, hold keeps data_ready high for ten cycles in total
  task automatic send_sample(input logic [15:0] s, input int ovr, input bit hold,
                             input string tag);
    logic [15:0] efo;
    bit          eclip;
    bit          early;
    bit          bad;
    bit          onek_exp;
    int          mw;
    bus.data_ready  = 1'b1;
    bus.sample_data = s;
    tick();
    for (int i = NT - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = s;
    model_out(efo, eclip);
    check({tag, "_err_clear"}, bus.err, 0);
    mw    = bus.modwait ? 1 : 0;
    early = 1'b0;
    for (int j = 1; j <= NT; j++) begin
      bus.data_ready  = hold || (j == ovr);
      bus.sample_data = 16'($urandom);
      tick();
      if (bus.modwait)   mw++;
      if (bus.out_valid) early = 1'b1;
    end
    bus.data_ready = hold;
    tick();
    m_outs++;
    onek_exp = (m_outs == SC);
    if (onek_exp) m_outs = 0;
    check({tag, "_valid"},   bus.out_valid, 1);
    check({tag, "_modwait"}, bus.modwait, 0);
    check({tag, "_busy"},    mw, NT + 1);
    check({tag, "_early"},   early, 0);
    check({tag, "_out"},     bus.fir_out, efo);
    check({tag, "_err"},     bus.err, eclip | (ovr != 0));
    check({tag, "_onek"},    bus.one_k_samples, onek_exp);
    tick();
    check({tag, "_vpulse"},  bus.out_valid, 0);
    check({tag, "_hold"},    bus.fir_out, efo);
    if (hold) begin
      bad = 1'b0;
      repeat (3) begin
        tick();
        if (bus.modwait || bus.out_valid) bad = 1'b1;
      end
      check({tag, "_retrig"}, bad, 0);
      bus.data_ready = 1'b0;
      tick();
    end
  endtask

  initial begin
    bus.load_coeff      = 1'b0;
    bus.coeff_valid     = 1'b0;
    bus.fir_coefficient = '0;
    bus.data_ready      = 1'b0;
    bus.sample_data     = '0;
    model_reset();

    // Power-on reset
    #1 rst = 1'b1;
    #1;
    check("rst_modwait", bus.modwait, 0);
    check("rst_valid",   bus.out_valid, 0);
    check("rst_out",     bus.fir_out, 0);
    check("rst_err",     bus.err, 0);
    check("rst_onek",    bus.one_k_samples, 0);
    tick();
    rst = 1'b0;
    tick();

    // Reference coefficient set and three samples
    cq = {16'h8000, 16'hC000, 16'h4000, 16'h2000};
    load_coeffs(1'b0);
    send_sample(16'h1234, 0, 1'b0, "t2a");
    check("t2a_const", bus.fir_out, 16'h1234);
    send_sample(16'h2345, 0, 1'b0, "t2b");
    check("t2b_const", bus.fir_out, 16'h07F7);
    send_sample(16'h4321, 0, 1'b0, "t2c");
    check("t2c_const", bus.fir_out, T2_THIRD);

    // Negative result clips to zero; next accept clears err
    send_sample(16'h0000, 0, 1'b0, "t3a");
    check("t3a_const", bus.fir_out, 16'h0000);
    check("t3a_errc",  bus.err, 1);
    send_sample(16'($urandom), 0, 1'b0, "t3b");

    // Full-scale coefficients: clip high, then clip low
    do_reset();
    cq = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    load_coeffs(1'b0);
    send_sample(16'hFFFF, 0, 1'b0, "t4a");
    check("t4a_const", bus.fir_out, 16'hFFFF);
    send_sample(16'h0000, 0, 1'b0, "t4b");
    check("t4b_const", bus.fir_out, 16'h0000);

    // Overlong load with a coincident sample edge, overrun, held strobe
    random_coeffs();
    cq.push_back(16'($urandom));
    cq.push_back(16'($urandom_range(0, 16'h3FFF)));
    load_coeffs(1'b1);
    send_sample(16'($urandom), 2, 1'b0, "t5a");
    send_sample(16'($urandom), 0, 1'b1, "t5b");

    // Reset asserted mid-computation
    bus.data_ready  = 1'b1;
    bus.sample_data = 16'h5A5A;
    tick();
    bus.data_ready = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("t1_modwait", bus.modwait, 0);
    check("t1_valid",   bus.out_valid, 0);
    check("t1_out",     bus.fir_out, 0);
    check("t1_err",     bus.err, 0);
    check("t1_onek",    bus.one_k_samples, 0);
    tick();
    rst = 1'b0;
    tick();
    model_reset();
    random_coeffs();
    load_coeffs(1'b0);
    send_sample(16'($urandom), 0, 1'b0, "t1b");

    // Randomized run across two coefficient sets, exercising the output counter
    for (int n = 0; n < 7; n++) begin
      if (n == 3) begin
        random_coeffs();
        load_coeffs(1'b0);
      end
      send_sample(16'($urandom), 0, 1'b0, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/param_fir_filter.md
Name: param_fir_filter

Overview:
- Parametrised successor to the fixed 4-tap, 16-bit FIR filter.
- Tap count, sample width, coefficient width and output-counter period are parameters.
- One multiply-accumulate per clock. Even taps add and odd taps subtract. The result saturates to the unsigned output range and raises err on clip.
- Sits between the sample-source handshake (data_ready/modwait) and the output sink. Coefficients are loaded through a serial port.

Parameters:
NUM_TAPS, 4, number of taps / coefficient slots (>=2)
DATA_W, 16, sample and fir_out width, unsigned
COEFF_W, 16, coefficient width, unsigned fixed point Q1.(COEFF_W-1)
SAMPLE_CNT, 1000, number of completed outputs per one_k_samples pulse

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
load_coeff  in  1  level; enables the coefficient-load session
coeff_valid  in  1  one coefficient write per cycle while high during a load session
fir_coefficient  in  COEFF_W  coefficient data
data_ready  in  1  sample strobe; its rising edge requests a sample
sample_data  in  DATA_W  sample, sampled on the data_ready rising edge
modwait  out  1  busy; high from sample accept until output written
out_valid  out  1  one-cycle pulse when fir_out updates
fir_out  out  DATA_W  filtered, saturated result
err  out  1  sticky until the next accepted sample: clip or overrun
one_k_samples  out  1  one-cycle pulse every SAMPLE_CNT outputs

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - Coefficients, sample history, accumulator, counters and load index are all cleared to 0.
  - All outputs are 0.
- States:
  - IDLE: if load_coeff=1 go to LOAD; else on a data_ready rising edge go to MAC.
  - LOAD: exit to IDLE when load_coeff=0.
  - MAC: NUM_TAPS cycles, tap index 0..NUM_TAPS-1, then go to OUT.
  - OUT: one cycle, then go to IDLE.
- Rising-edge detect: data_ready is registered once. Holding data_ready high never retriggers.
- LOAD:
  - Each cycle with coeff_valid=1 writes fir_coefficient into slot[idx] and increments idx.
  - idx saturates at NUM_TAPS-1; extra writes overwrite the last slot.
  - idx returns to 0 when LOAD exits. Slots not written keep their old values.
- Accept (IDLE, data_ready edge, load_coeff=0):
  - History shifts: newest sample goes to tap0, oldest is dropped.
  - Accumulator clears; err clears; modwait goes to 1 on the same edge.
- Tap sum: acc = sum over i of (-1)^i * sample[i]*coeff[i].
  - acc is signed, width DATA_W+COEFF_W+clog2(NUM_TAPS)+1; it never wraps.
- OUT edge:
  - result = acc >>> (COEFF_W-1), arithmetic shift, truncated.
  - result<0 gives fir_out=0 and err=1.
  - result>2^DATA_W-1 gives fir_out=all ones and err=1.
  - Otherwise fir_out=result.
  - out_valid=1 for one cycle; modwait goes to 0 on the same edge.
- Latency: accept at edge k. fir_out and out_valid appear at edge k+NUM_TAPS+1. modwait is high for NUM_TAPS+1 cycles.
- Overrun: a data_ready rising edge while modwait=1 or in LOAD drops the sample and sets err=1. The current computation is unaffected.
- load_coeff during MAC/OUT: ignored until return to IDLE; LOAD entered next cycle if still high.
- Simultaneous load_coeff=1 and data_ready edge in IDLE: LOAD wins; sample dropped, err=1.
- Output counter:
  - Increments at each OUT.
  - On reaching SAMPLE_CNT: one_k_samples pulses with that out_valid and the counter wraps to 0.
- fir_out holds its value between outputs.

Optional Feature:
FIR_ROUND_EN
- Defined: adds 2^(COEFF_W-2) to acc before the shift (round half up), then saturates as normal.
- Undefined: truncation only, no adder.

Test Plan:
1. Reset mid-MAC (rst pulsed during MAC) -> modwait, out_valid, fir_out, err, one_k_samples all 0 asynchronously; next sample sees zeroed history.
2. Load coefficients 0x8000, 0xC000, 0x4000, 0x2000 with coeff_valid. Then samples 0x1234, 0x2345, 0x4321 -> fir_out 0x1234, 0x07F7, 0x1753, err=0. Each result arrives 5 edges after accept; modwait high 5 cycles. With FIR_ROUND_EN the third output is 0x1754.
3. Follow test 2 with sample 0x0000 -> result -22428, fir_out=0x0000, err=1. Next accepted sample clears err.
4. Coefficients all 0xFFFF, sample 0xFFFF then 0x0000 -> first output clips high, then history [0, 0xFFFF, 0, 0] clips low; err=1 both.
5. Second data_ready edge 2 cycles after accept -> err=1, sample dropped, output value unchanged. data_ready held 10 cycles -> exactly one accept.
6. SAMPLE_CNT=3, 7 samples -> one_k_samples pulses with outputs 3 and 6 only.
